// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and the
// request record that drives the shared memory port.
package mem_arb_types;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MBE_W  = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_BUSY = 3'd1,
        D_BUSY = 3'd2,
        I_DONE = 3'd3,
        D_DONE = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MBE_W-1:0]  mbe;
        logic              read;
        logic              write;
    } mem_req_t;

    function automatic mem_req_t make_req(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata,
        input logic [MBE_W-1:0]  mbe,
        input logic              read,
        input logic              write
    );
        mem_req_t r;
        r.addr  = addr;
        r.wdata = wdata;
        r.mbe   = mbe;
        r.read  = read;
        r.write = write;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and shared memory port signals.
// slave = the arbiter's view, master = requesters plus memory.
interface mem_port_arbiter_if;
    import mem_arb_types::*;

    logic              inst_read;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_resp;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_read;
    logic              data_write;
    logic [MBE_W-1:0]  data_mbe;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_resp;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [MBE_W-1:0]  mem_mbe;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_resp;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  inst_read, inst_addr,
        input  data_read, data_write, data_mbe, data_addr, data_wdata,
        input  mem_resp, mem_rdata,
        output inst_resp, inst_rdata, data_resp, data_rdata,
        output mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
    );

    modport master (
        output inst_read, inst_addr,
        output data_read, data_write, data_mbe, data_addr, data_wdata,
        output mem_resp, mem_rdata,
        input  inst_resp, inst_rdata, data_resp, data_rdata,
        input  mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_chk.sv
// Protocol checker for the load/store requester: read and write together
// is illegal; each offending cycle is flagged and counted.
module mem_port_arbiter_chk (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_read,
    input  logic       data_write,
    output logic [7:0] illegal_cnt
);

    // saturating count of cycles with both load and store requested
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= 8'd0;
        end else if (data_read && data_write && (illegal_cnt != 8'hFF)) begin
            illegal_cnt <= illegal_cnt + 8'd1;
        end else begin
            illegal_cnt <= illegal_cnt;
        end
    end

    illegal_rw_a: assert property (@(posedge clk) disable iff (rst) !(data_read && data_write))
        else $warning("data_read and data_write asserted together; treated as a write");

endmodule

// File: rtl/mem_port_arbiter_req_reg.sv
// Loadable request register whose contents drive the shared memory port.
// clear wins over load so an access can be retired in the same edge.
module arb_req_reg
    import mem_arb_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     clear,
    input  mem_req_t req_d,
    output mem_req_t req_q
);

    // request register: reset/clear to idle, load on grant, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else if (clear) begin
            req_q <= '0;
        end else if (load) begin
            req_q <= req_d;
        end else begin
            req_q <= req_q;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and data load/store requests onto one shared
// memory port, returning a registered one-cycle response to the served side.
module mem_port_arbiter
    import mem_arb_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int          SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] SL = SW'(STARVE_LIMIT);

    arb_state_t        state_r;
    logic [SW-1:0]     streak_r;
    logic              inst_resp_r;
    logic              data_resp_r;
    logic [DATA_W-1:0] inst_rdata_r;
    logic [DATA_W-1:0] data_rdata_r;

    logic     data_req_s;
    logic     starve_s;
    logic     grant_d_s;
    logic     grant_i_s;
    logic     done_s;
    mem_req_t req_d_s;
    mem_req_t req_q_s;

    // grant decision in IDLE and the request record to latch
    always_comb begin
        data_req_s = bus.data_read | bus.data_write;
        starve_s   = bus.inst_read && (STARVE_LIMIT != 0) && (streak_r == SL);
        grant_d_s  = (state_r == IDLE) && data_req_s && !starve_s;
        grant_i_s  = (state_r == IDLE) && bus.inst_read && !grant_d_s;
        done_s     = ((state_r == I_BUSY) || (state_r == D_BUSY)) && bus.mem_resp;
        req_d_s    = '0;
        if (grant_d_s) begin
            // a simultaneous read+write is performed as a write
            req_d_s = make_req(bus.data_addr, bus.data_wdata,
                               bus.data_write ? bus.data_mbe : {MBE_W{1'b1}},
                               bus.data_read & ~bus.data_write, bus.data_write);
        end else if (grant_i_s) begin
            req_d_s = make_req(bus.inst_addr, {DATA_W{1'b0}}, {MBE_W{1'b1}}, 1'b1, 1'b0);
        end else begin
            req_d_s = '0;
        end
    end

    arb_req_reg u_req_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (grant_d_s | grant_i_s),
        .clear (done_s),
        .req_d (req_d_s),
        .req_q (req_q_s)
    );

    // arbitration FSM, starvation streak and registered responses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            streak_r     <= {SW{1'b0}};
            inst_resp_r  <= 1'b0;
            data_resp_r  <= 1'b0;
            inst_rdata_r <= {DATA_W{1'b0}};
            data_rdata_r <= {DATA_W{1'b0}};
        end else begin
            inst_resp_r <= 1'b0;
            data_resp_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        state_r  <= D_BUSY;
                        streak_r <= !bus.inst_read ? {SW{1'b0}} :
                                    (streak_r == SL) ? SL : streak_r + SW'(1);
                    end else if (grant_i_s) begin
                        state_r  <= I_BUSY;
                        streak_r <= {SW{1'b0}};
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                D_BUSY: begin
                    if (bus.mem_resp) begin
                        state_r     <= D_DONE;
                        data_resp_r <= 1'b1;
                        if (req_q_s.read) begin
                            data_rdata_r <= bus.mem_rdata;
                        end
                    end
                end
                I_BUSY: begin
                    if (bus.mem_resp) begin
                        state_r      <= I_DONE;
                        inst_resp_r  <= 1'b1;
                        inst_rdata_r <= bus.mem_rdata;
                    end
                end
                D_DONE:  state_r <= IDLE;
                I_DONE:  state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.mem_read   = req_q_s.read;
    assign bus.mem_write  = req_q_s.write;
    assign bus.mem_mbe    = req_q_s.mbe;
    assign bus.mem_addr   = req_q_s.addr;
    assign bus.mem_wdata  = req_q_s.wdata;
    assign bus.inst_resp  = inst_resp_r;
    assign bus.inst_rdata = inst_rdata_r;
    assign bus.data_resp  = data_resp_r;
    assign bus.data_rdata = data_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table of single accesses,
// a response scoreboard, and sequences for contention, starvation and reset.
module tb_mem_port_arbiter;
    import mem_arb_types::*;

    typedef struct {
        logic        is_inst;
        logic        rd;
        logic        wr;
        logic [3:0]  mbe;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        req_t        r;
        int          lat;
        logic        exp_rd;
        logic        exp_wr;
        logic [3:0]  exp_mbe;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] illegal_cnt;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    mem_port_arbiter_chk chk (.clk(clk), .rst(rst), .data_read(bus.data_read),
                              .data_write(bus.data_write), .illegal_cnt(illegal_cnt));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a == 32'h60) ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] mbe);
        logic [31:0] res = old;
        for (int b = 0; b < 4; b++) if (mbe[b]) res[8*b +: 8] = wd[8*b +: 8];
        return res;
    endfunction

    // memory model: responds mem_lat cycles after mem_* appears, logs grants
    logic [31:0] phys_mem [logic [31:0]];
    int   mem_lat = 1;
    int   mcnt = 0;
    bit   mem_manual = 1'b0, man_resp = 1'b0, prev_act = 1'b0;
    logic [31:0] man_data = 32'h0;
    bit   gside[$];
    bit   gwr[$];
    int   gstreak[$];
    int   gcyc[$];

    function automatic logic [31:0] phys_get(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : pat(a);
    endfunction

    always @(negedge clk) begin
        if (mem_manual) begin
            bus.mem_resp  = man_resp;
            bus.mem_rdata = man_data;
            mcnt = 0;
        end else if ((bus.mem_read || bus.mem_write) && !bus.mem_resp) begin
            mcnt = mcnt + 1;
            if (mcnt >= mem_lat) begin
                bus.mem_resp = 1'b1;
                if (bus.mem_write) begin
                    phys_mem[bus.mem_addr] = merge(phys_get(bus.mem_addr), bus.mem_wdata, bus.mem_mbe);
                    bus.mem_rdata = 32'hBAD0_0000;
                end else begin
                    bus.mem_rdata = phys_get(bus.mem_addr);
                end
            end
        end else begin
            mcnt = 0;
            bus.mem_resp  = 1'b0;
            bus.mem_rdata = 32'hDEAD_BEEF;
        end
        if ((bus.mem_read || bus.mem_write) && !prev_act) begin
            gside.push_back(bus.mem_addr < 32'h100);
            gwr.push_back(bus.mem_write);
            gstreak.push_back(int'(dut.streak_r));
            gcyc.push_back(cyc);
        end
        prev_act = bus.mem_read || bus.mem_write;
    end

    // scoreboard: expected rdata queued at request time, popped on resp
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] inst_q[$];
    logic [31:0] data_q[$];
    logic [31:0] last_i = 32'h0, last_d = 32'h0;
    bit prev_iresp = 1'b0, prev_dresp = 1'b0;
    int dresp_cyc = 0;
    int dresp_seen = 0;

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_iresp = 1'b0;
            prev_dresp = 1'b0;
        end else begin
            if (bus.inst_resp) begin
                check("inst_resp_width", {31'd0, prev_iresp}, 32'd0);
                if (inst_q.size() == 0) check("inst_resp_unexpected", {31'd0, bus.inst_resp}, 32'd0);
                else check("inst_rdata", bus.inst_rdata, inst_q.pop_front());
            end
            if (bus.data_resp) begin
                dresp_seen++;
                dresp_cyc = cyc;
                check("data_resp_width", {31'd0, prev_dresp}, 32'd0);
                if (data_q.size() == 0) check("data_resp_unexpected", {31'd0, bus.data_resp}, 32'd0);
                else check("data_rdata", bus.data_rdata, data_q.pop_front());
            end
            prev_iresp = bus.inst_resp;
            prev_dresp = bus.data_resp;
        end
    end

    task automatic drive_req(input req_t r);
        logic [31:0] e;
        if (r.is_inst) begin
            bus.inst_read = 1'b1;
            bus.inst_addr = r.addr;
            last_i = ref_get(r.addr);
            inst_q.push_back(last_i);
        end else begin
            bus.data_read  = r.rd;
            bus.data_write = r.wr;
            bus.data_addr  = r.addr;
            bus.data_wdata = r.wdata;
            bus.data_mbe   = r.mbe;
            if (r.wr) begin
                ref_mem[r.addr] = merge(ref_get(r.addr), r.wdata, r.mbe);
                e = last_d;
            end else begin
                e = ref_get(r.addr);
                last_d = e;
            end
            data_q.push_back(e);
        end
    endtask

    task automatic release_req(input logic is_inst);
        if (is_inst) bus.inst_read = 1'b0;
        else begin
            bus.data_read  = 1'b0;
            bus.data_write = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  t0;
        bit  seen = 1'b0;
        mem_lat = v.lat;
        drive_req(v.r);
        t0 = cyc;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_read || bus.mem_write) seen = 1'b1;
        end
        check({tag, "_mem_start"}, 32'(cyc - t0), 32'd1);
        check({tag, "_mem_read"},  {31'd0, bus.mem_read},  {31'd0, v.exp_rd});
        check({tag, "_mem_write"}, {31'd0, bus.mem_write}, {31'd0, v.exp_wr});
        check({tag, "_mem_mbe"},   {28'd0, bus.mem_mbe},   {28'd0, v.exp_mbe});
        check({tag, "_mem_addr"},  bus.mem_addr, v.r.addr);
        if (v.r.wr) check({tag, "_mem_wdata"}, bus.mem_wdata, v.r.wdata);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (v.r.is_inst ? bus.inst_resp : bus.data_resp) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(cyc - t0), 32'(v.exp_lat));
        check({tag, "_mem_dropped"}, {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        release_req(v.r.is_inst);
        @(negedge clk);
    endtask

    // drives queued requests per side, re-presenting after each resp
    task automatic run_multi(input req_t ip[$], input req_t dp[$], input int budget);
        bit ia = 1'b0, da = 1'b0;
        if (ip.size() != 0) begin drive_req(ip.pop_front()); ia = 1'b1; end
        if (dp.size() != 0) begin drive_req(dp.pop_front()); da = 1'b1; end
        for (int c = 0; c < budget && (ia || da); c++) begin
            @(negedge clk);
            if (ia && bus.inst_resp) begin
                if (ip.size() != 0) drive_req(ip.pop_front());
                else begin release_req(1'b1); ia = 1'b0; end
            end
            if (da && bus.data_resp) begin
                if (dp.size() != 0) drive_req(dp.pop_front());
                else begin release_req(1'b0); da = 1'b0; end
            end
        end
        check("run_timeout", {30'd0, ia, da}, 32'd0);
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {27'd0, bus.mem_read, bus.mem_write, bus.mem_mbe[2:0] != 3'd0 || bus.mem_mbe[3],
                              bus.inst_resp, bus.data_resp}, 32'd0);
        check({tag, "_mem_addr"},   bus.mem_addr,   32'd0);
        check({tag, "_mem_wdata"},  bus.mem_wdata,  32'd0);
        check({tag, "_inst_rdata"}, bus.inst_rdata, 32'd0);
        check({tag, "_data_rdata"}, bus.data_rdata, 32'd0);
    endtask

    vec_t vecs[7];
    req_t ip[$];
    req_t dp[$];
    req_t rq;
    int   base;
    bit   exp_side[7];
    int   exp_streak[7];

    initial begin
        vecs[0] = '{'{1'b1, 1'b1, 1'b0, 4'hF, 32'h60,  32'h0},        2, 1'b1, 1'b0, 4'hF,    3};
        vecs[1] = '{'{1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0},        1, 1'b1, 1'b0, 4'hF,    2};
        vecs[2] = '{'{1'b0, 1'b0, 1'b1, 4'b0100, 32'h100, 32'h00AB_0000}, 1, 1'b0, 1'b1, 4'b0100, 2};
        vecs[3] = '{'{1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0},        3, 1'b1, 1'b0, 4'hF,    4};
        vecs[4] = '{'{1'b1, 1'b1, 1'b0, 4'hF, 32'h44,  32'h0},        1, 1'b1, 1'b0, 4'hF,    2};
        vecs[5] = '{'{1'b0, 1'b0, 1'b1, 4'b1001, 32'h204, 32'hCAFE_F00D}, 2, 1'b0, 1'b1, 4'b1001, 3};
        vecs[6] = '{'{1'b0, 1'b1, 1'b0, 4'hF, 32'h204, 32'h0},        1, 1'b1, 1'b0, 4'hF,    2};
        exp_side   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_streak = '{1, 2, 3, 4, 0, 0, 0};

        rst = 1'b1;
        bus.inst_read = 1'b0;  bus.inst_addr = 32'h0;
        bus.data_read = 1'b0;  bus.data_write = 1'b0;
        bus.data_mbe = 4'h0;   bus.data_addr = 32'h0;  bus.data_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // contention: data wins, inst follows straight after the DONE cycle
        mem_lat = 2;
        base = gside.size();
        ip = '{'{1'b1, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0}};
        dp = '{'{1'b0, 1'b1, 1'b0, 4'hF, 32'h208, 32'h0}};
        run_multi(ip, dp, 40);
        check("simul_count", 32'(gside.size() - base), 32'd2);
        if (gside.size() - base == 2) begin
            check("simul_order", {30'd0, gside[base], gside[base+1]}, 32'b01);
            check("simul_gap", 32'(gcyc[base+1] - dresp_cyc), 32'd2);
        end

        // starvation: one fetch against six back-to-back loads
        mem_lat = 1;
        base = gside.size();
        ip = '{'{1'b1, 1'b1, 1'b0, 4'hF, 32'h60, 32'h0}};
        dp.delete();
        for (int i = 0; i < 6; i++) begin
            rq = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h300 + 32'(4 * i), 32'h0};
            dp.push_back(rq);
        end
        run_multi(ip, dp, 100);
        check("starve_count", 32'(gside.size() - base), 32'd7);
        for (int i = 0; i < 7 && (base + i) < gside.size(); i++) begin
            check($sformatf("starve_side%0d", i), {31'd0, gside[base+i]}, {31'd0, exp_side[i]});
            check($sformatf("starve_streak%0d", i), 32'(gstreak[base+i]), 32'(exp_streak[i]));
        end

        // illegal read+write: performed as a write and flagged by the checker
        base = gside.size();
        ip.delete();
        dp = '{'{1'b0, 1'b1, 1'b1, 4'b0011, 32'h400, 32'h1122_3344}};
        run_multi(ip, dp, 20);
        check("illegal_count", 32'(gside.size() - base), 32'd1);
        if (gside.size() > base) check("illegal_is_write", {31'd0, gwr[base]}, 32'd1);
        check("illegal_flagged", {31'd0, illegal_cnt != 8'd0}, 32'd1);
        run_vec('{'{1'b0, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0}, 1, 1'b1, 1'b0, 4'hF, 2}, "illegal_rb");

        // reset while D_BUSY: access abandoned, late mem_resp ignored
        mem_manual = 1'b1;
        man_resp = 1'b0;
        man_data = 32'h1234_5678;
        bus.data_read = 1'b1;
        bus.data_addr = 32'h500;
        for (int i = 0; i < 5 && !bus.mem_read; i++) @(negedge clk);
        check("rst_busy_mem_read", {31'd0, bus.mem_read}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("rst_mid");
        rst = 1'b0;
        bus.data_read = 1'b0;
        last_d = 32'h0;
        last_i = 32'h0;
        dresp_seen = 0;
        man_resp = 1'b1;
        repeat (2) @(negedge clk);
        man_resp = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_no_data_resp", 32'(dresp_seen), 32'd0);
        check("rst_mem_idle", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        mem_manual = 1'b0;
        @(negedge clk);
        run_vec(vecs[4], "post_rst");

        check("sb_inst_drained", 32'(inst_q.size()), 32'd0);
        check("sb_data_drained", 32'(data_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
